tlb_unit: RTL and testbench
===========================

# tlb_unit

16-entry, fully associative MIPS32 joint TLB that sits directly downstream of the CP0 register file. It holds translation entries written from CP0 EntryHi/EntryLo0/EntryLo1/Index on TLBWI. It returns entries to CP0 on TLBR in the 78-bit `TLB_rdata` format and the `index_write_p`/`index_write_index` result on TLBP. It also serves two registered lookup ports, one for instruction fetch (s0) and one for data access (s1).

## Interface
- `TLBNUM`, 16: number of entries; index width is log2(TLBNUM) = 4.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `s0_req` in 1: fetch lookup request.
- `s0_vpn2` in 19: VA[31:13] for the fetch lookup.
- `s0_odd_page` in 1: VA[12] for the fetch lookup.
- `s1_req` in 1: data lookup request.
- `s1_vpn2` in 19: VA[31:13] for the data lookup.
- `s1_odd_page` in 1: VA[12] for the data lookup.
- `s0_found`, `s1_found` out 1: a matching entry exists.
- `s0_index`, `s1_index` out 4: index of the matching entry.
- `s0_pfn`, `s1_pfn` out 20: PFN of the selected page.
- `s0_c`, `s1_c` out 3: C bits of the selected page.
- `s0_d`, `s1_d` out 1: D bit of the selected page.
- `s0_v`, `s1_v` out 1: V bit of the selected page.
- `cp0_index` in 32: CP0 Index register; bits [3:0] are used.
- `cp0_entryhi` in 32: {VPN2[31:13], 0, ASID[7:0]}.
- `cp0_entrylo0` in 32: {PFN[25:6], C[5:3], D, V, G}.
- `cp0_entrylo1` in 32: same layout as `cp0_entrylo0`.
- `tlbwi` in 1: write pulse from WB.
- `tlbr` in 1: read pulse from WB.
- `tlbp` in 1: probe pulse from WB.
- `is_TLBR` out 1: TLBR result valid; goes to CP0.
- `TLB_rdata` out 78: read-back entry.
- `is_TLBP` out 1: TLBP result valid.
- `index_write_p` out 1: 1 = probe miss.
- `index_write_index` out 4: index of the probe hit.

## Operation
- Entry storage per index: VPN2[18:0], ASID[7:0], G, and per page PFN[19:0], C[2:0], D, V.
- `TLB_rdata` packing: {VPN2[77:59], ASID[58:51], G[50], PFN0[49:30], C0[29:27], D0[26], V0[25], PFN1[24:5], C1[4:2], D1[1], V1[0]}.
- Match rule for entry i: `(VPN2_i == vpn2) && (G_i || ASID_i == cp0_entryhi[7:0])`.
  - The ASID is sampled in the request cycle.
- Lookup: page select uses `odd_page`, 0 = page0 and 1 = page1.
  - With multiple matches, the lowest index wins; this is software error, but the result must be deterministic.
  - On a miss: `found=0` and `index`/`pfn`/`c`/`d`/`v` = 0.
- TLBWI: writes entry `cp0_index[3:0]`.
  - VPN2 comes from `cp0_entryhi[31:13]`, ASID from `cp0_entryhi[7:0]`.
  - G is set to `cp0_entrylo0[0] & cp0_entrylo1[0]`.
  - Page0 takes `cp0_entrylo0[25:1]`; page1 takes `cp0_entrylo1[25:1]`.
- TLBR: captures entry `cp0_index[3:0]` into `TLB_rdata` and asserts `is_TLBR`.
- TLBP: matches `cp0_entryhi[31:13]` and ASID against all entries.
  - Hit: `index_write_p=0`, `index_write_index` = lowest matching index.
  - Miss: `index_write_p=1`, `index_write_index=0`.
- `tlbwi`/`tlbr`/`tlbp` are mutually exclusive. If more than one is asserted, priority is tlbwi > tlbp > tlbr, and the lower-priority request is dropped.
- Reset: all V0/V1/G bits and all VPN2 fields are cleared. PFN/C/D/ASID are don't-care after reset; they read as 0 via V-gating only where stated.

## Timing
- Lookup latency: 1 cycle.
  - A request in cycle N produces results valid in cycle N+1, held until the next request on that port.
  - No request means outputs hold their value.
- Write visibility: TLBWI in cycle N updates storage at the N→N+1 edge.
  - A lookup or probe issued in cycle N sees the OLD contents.
  - A lookup or probe issued in cycle N+1 sees the NEW contents.
- TLBR/TLBP results: registered, with `is_TLBR`/`is_TLBP` high for exactly cycle N+1.
  - `TLB_rdata`/`index_write_*` hold their value after the pulse ends.
- Reset values of all outputs: every `s*_*` = 0, `is_TLBR=0`, `is_TLBP=0`, `TLB_rdata=0`, `index_write_p=0`, `index_write_index=0`.
- Reset asserted mid-operation: any pending result is discarded, and the cycle after reset deasserts shows reset values.
- Both lookup ports and a CP0 op may be active in the same cycle with no stall; there is no back-pressure.

## Test plan
- After reset, `s0_req=1`, `s0_vpn2=19'h00400` → next cycle `s0_found=0` and all s0 fields 0.
- TLBWI at index 3 with entryhi=0x00800_0A5 (VPN2=0x00400, ASID=0xA5), lo0 PFN=0x12345 V=1 D=1 C=3 G=0, lo1 PFN=0x54321 V=1 G=0; then s1 lookup with vpn2=0x00400, odd=1, ASID 0xA5 → `s1_found=1`, `index=3`, `pfn=0x54321`.
- Same entry, lookup with ASID 0x11 → miss. Rewrite the entry with G=1 in both lo0 and lo1 → hit with any ASID.
- TLBWI and an s0 lookup of the same VPN2 in the same cycle → the lookup misses. A repeat lookup one cycle later hits.
- TLBP for a VPN2 present at indices 5 and 9 → `is_TLBP` pulses, `index_write_p=0`, `index_write_index=5`. TLBP for an absent VPN2 → `index_write_p=1`.
- TLBR with `cp0_index=3` → `is_TLBR` pulses one cycle later, and `TLB_rdata` exactly matches the packed written fields, including G[50].

Source files
------------

// File: rtl/tlb_unit.sv
// tlb_unit: 16-entry fully associative MIPS32 joint TLB.
//   clk, reset                     : single clock, synchronous active-high reset
//   s0_* / s1_*                    : fetch / data lookup ports, registered, 1-cycle latency
//   cp0_index/entryhi/entrylo0/1   : CP0 source registers for TLBWI/TLBP/TLBR
//   tlbwi, tlbr, tlbp              : op pulses from WB (priority tlbwi > tlbp > tlbr)
//   is_TLBR, TLB_rdata             : TLBR result pulse and packed 78-bit entry
//   is_TLBP, index_write_p/_index  : TLBP result pulse, miss flag and hit index
module tlb_unit #(
  parameter int TLBNUM = 16,
  localparam int IDX_W = $clog2(TLBNUM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s0_req,
  input  logic [18:0]      s0_vpn2,
  input  logic             s0_odd_page,
  output logic             s0_found,
  output logic [IDX_W-1:0] s0_index,
  output logic [19:0]      s0_pfn,
  output logic [2:0]       s0_c,
  output logic             s0_d,
  output logic             s0_v,
  input  logic             s1_req,
  input  logic [18:0]      s1_vpn2,
  input  logic             s1_odd_page,
  output logic             s1_found,
  output logic [IDX_W-1:0] s1_index,
  output logic [19:0]      s1_pfn,
  output logic [2:0]       s1_c,
  output logic             s1_d,
  output logic             s1_v,
  input  logic [31:0]      cp0_index,
  input  logic [31:0]      cp0_entryhi,
  input  logic [31:0]      cp0_entrylo0,
  input  logic [31:0]      cp0_entrylo1,
  input  logic             tlbwi,
  input  logic             tlbr,
  input  logic             tlbp,
  output logic             is_TLBR,
  output logic [77:0]      TLB_rdata,
  output logic             is_TLBP,
  output logic             index_write_p,
  output logic [IDX_W-1:0] index_write_index
);

  // Control state (reset): VPN2, G and the two V bits.
  logic [18:0] vpn2_q [TLBNUM];
  logic        g_q    [TLBNUM];
  logic        v0_q   [TLBNUM];
  logic        v1_q   [TLBNUM];
  // Data state (no reset): ASID and per-page {PFN, C, D}.
  logic [7:0]  asid_q [TLBNUM];
  logic [23:0] pg0_q  [TLBNUM];
  logic [23:0] pg1_q  [TLBNUM];

  logic [IDX_W-1:0] wr_idx;
  logic [7:0]       cur_asid;
  logic             do_tlbp, do_tlbr;
  logic [TLBNUM-1:0] s0_hit, s1_hit, p_hit;
  logic [IDX_W-1:0] s0_sel, s1_sel, p_sel;
  logic [24:0]      s0_page, s1_page;

  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{cp0_index[31:IDX_W], cp0_entryhi[12:8],
                             cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

  assign wr_idx   = cp0_index[IDX_W-1:0];
  assign cur_asid = cp0_entryhi[7:0];
  assign do_tlbp  = tlbp & ~tlbwi;
  assign do_tlbr  = tlbr & ~tlbwi & ~tlbp;

  // Lowest matching index wins so duplicate entries resolve deterministically.
  function automatic logic [IDX_W-1:0] first_idx(input logic [TLBNUM-1:0] hv);
    first_idx = '0;
    for (int i = TLBNUM - 1; i >= 0; i--)
      if (hv[i]) first_idx = i[IDX_W-1:0];
  endfunction

  always_comb begin
    s0_hit = '0;
    s1_hit = '0;
    p_hit  = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      s0_hit[i] = (vpn2_q[i] == s0_vpn2) && (g_q[i] || asid_q[i] == cur_asid);
      s1_hit[i] = (vpn2_q[i] == s1_vpn2) && (g_q[i] || asid_q[i] == cur_asid);
      p_hit[i]  = (vpn2_q[i] == cp0_entryhi[31:13]) && (g_q[i] || asid_q[i] == cur_asid);
    end
  end

  assign s0_sel  = first_idx(s0_hit);
  assign s1_sel  = first_idx(s1_hit);
  assign p_sel   = first_idx(p_hit);
  assign s0_page = s0_odd_page ? {pg1_q[s0_sel], v1_q[s0_sel]} : {pg0_q[s0_sel], v0_q[s0_sel]};
  assign s1_page = s1_odd_page ? {pg1_q[s1_sel], v1_q[s1_sel]} : {pg0_q[s1_sel], v0_q[s1_sel]};

  // Storage update: TLBWI in cycle N is visible to requests from cycle N+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) begin
        vpn2_q[i] <= '0;
        g_q[i]    <= 1'b0;
        v0_q[i]   <= 1'b0;
        v1_q[i]   <= 1'b0;
      end
    end else if (tlbwi) begin
      vpn2_q[wr_idx] <= cp0_entryhi[31:13];
      g_q[wr_idx]    <= cp0_entrylo0[0] & cp0_entrylo1[0];
      v0_q[wr_idx]   <= cp0_entrylo0[1];
      v1_q[wr_idx]   <= cp0_entrylo1[1];
    end
  end

  always_ff @(posedge clk) begin
    if (tlbwi) begin
      asid_q[wr_idx] <= cp0_entryhi[7:0];
      pg0_q[wr_idx]  <= cp0_entrylo0[25:2];
      pg1_q[wr_idx]  <= cp0_entrylo1[25:2];
    end
  end

  // ---- stage p1: registered lookup and CP0 op results ----
  logic             s0_found_p1, s1_found_p1;
  logic [IDX_W-1:0] s0_index_p1, s1_index_p1;
  logic [24:0]      s0_page_p1, s1_page_p1;
  logic             vld_tlbr_p1, vld_tlbp_p1;
  logic [77:0]      rdata_p1;
  logic             iw_p_p1;
  logic [IDX_W-1:0] iw_index_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_found_p1 <= 1'b0;
      s0_index_p1 <= '0;
      s0_page_p1  <= '0;
      s1_found_p1 <= 1'b0;
      s1_index_p1 <= '0;
      s1_page_p1  <= '0;
      vld_tlbr_p1 <= 1'b0;
      vld_tlbp_p1 <= 1'b0;
      rdata_p1    <= '0;
      iw_p_p1     <= 1'b0;
      iw_index_p1 <= '0;
    end else begin
      if (s0_req) begin
        s0_found_p1 <= |s0_hit;
        s0_index_p1 <= (|s0_hit) ? s0_sel  : '0;
        s0_page_p1  <= (|s0_hit) ? s0_page : '0;
      end
      if (s1_req) begin
        s1_found_p1 <= |s1_hit;
        s1_index_p1 <= (|s1_hit) ? s1_sel  : '0;
        s1_page_p1  <= (|s1_hit) ? s1_page : '0;
      end
      vld_tlbr_p1 <= do_tlbr;
      vld_tlbp_p1 <= do_tlbp;
      if (do_tlbr)
        rdata_p1 <= {vpn2_q[wr_idx], asid_q[wr_idx], g_q[wr_idx],
                     pg0_q[wr_idx], v0_q[wr_idx], pg1_q[wr_idx], v1_q[wr_idx]};
      if (do_tlbp) begin
        iw_p_p1     <= ~(|p_hit);
        iw_index_p1 <= (|p_hit) ? p_sel : '0;
      end
    end
  end

  assign s0_found          = s0_found_p1;
  assign s0_index          = s0_index_p1;
  assign {s0_pfn, s0_c, s0_d, s0_v} = s0_page_p1;
  assign s1_found          = s1_found_p1;
  assign s1_index          = s1_index_p1;
  assign {s1_pfn, s1_c, s1_d, s1_v} = s1_page_p1;
  assign is_TLBR           = vld_tlbr_p1;
  assign TLB_rdata         = rdata_p1;
  assign is_TLBP           = vld_tlbp_p1;
  assign index_write_p     = iw_p_p1;
  assign index_write_index = iw_index_p1;

endmodule

// File: tb/tb_tlb_unit.sv
module tb_tlb_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        s0_req, s0_odd_page, s1_req, s1_odd_page;
  logic [18:0] s0_vpn2, s1_vpn2;
  logic        s0_found, s1_found, s0_d, s1_d, s0_v, s1_v;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_pfn, s1_pfn;
  logic [2:0]  s0_c, s1_c;
  logic [31:0] cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
  logic        tlbwi, tlbr, tlbp;
  logic        is_TLBR, is_TLBP, index_write_p;
  logic [77:0] TLB_rdata;
  logic [3:0]  index_write_index;
  logic [77:0] exp_rd;

  int passed = 0;
  int total  = 0;

  tlb_unit dut (
    .clk(clk), .reset(reset),
    .s0_req(s0_req), .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page),
    .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
    .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
    .s1_req(s1_req), .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page),
    .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
    .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
    .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi),
    .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
    .tlbwi(tlbwi), .tlbr(tlbr), .tlbp(tlbp),
    .is_TLBR(is_TLBR), .TLB_rdata(TLB_rdata), .is_TLBP(is_TLBP),
    .index_write_p(index_write_p), .index_write_index(index_write_index)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hi(input logic [18:0] vpn2, input logic [7:0] asid);
    hi = {vpn2, 5'b0, asid};
  endfunction

  function automatic logic [31:0] lo(input logic [19:0] pfn, input logic [2:0] c,
                                     input logic d, input logic v, input logic g);
    lo = {6'b0, pfn, c, d, v, g};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input logic [3:0] idx, input logic [31:0] h,
                             input logic [31:0] l0, input logic [31:0] l1);
    cp0_index = {28'b0, idx}; cp0_entryhi = h; cp0_entrylo0 = l0; cp0_entrylo1 = l1;
    tlbwi = 1'b1;
    tick();
    tlbwi = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    total++; if (s0_found !== 1'b0 || s0_index !== 4'd0 || s0_pfn !== 20'd0)
      $display("FAIL rst_s0 got %b/%h/%h exp 0/0/0", s0_found, s0_index, s0_pfn); else passed++;
    total++; if (is_TLBR !== 1'b0 || is_TLBP !== 1'b0 || TLB_rdata !== 78'd0)
      $display("FAIL rst_cp0 got %b/%b/%h exp 0/0/0", is_TLBR, is_TLBP, TLB_rdata); else passed++;
    total++; if (index_write_p !== 1'b0 || index_write_index !== 4'd0 || s1_found !== 1'b0)
      $display("FAIL rst_iw got %b/%h/%b exp 0/0/0", index_write_p, index_write_index, s1_found); else passed++;
    cp0_entryhi = hi(19'h00400, 8'hA5);
    s0_req = 1'b1; s0_vpn2 = 19'h00400; s0_odd_page = 1'b0;
    tick();
    s0_req = 1'b0;
    total++; if ({s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v} !== 30'd0)
      $display("FAIL rst_lookup got %b/%h/%h/%h/%b/%b exp all 0",
               s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v); else passed++;
  endtask

  task automatic test_write_lookup();
    write_entry(4'd3, hi(19'h00400, 8'hA5), lo(20'h12345, 3'd3, 1'b1, 1'b1, 1'b0),
                lo(20'h54321, 3'd0, 1'b0, 1'b1, 1'b0));
    cp0_entryhi = hi(19'h00000, 8'hA5);
    s1_req = 1'b1; s1_vpn2 = 19'h00400; s1_odd_page = 1'b1;
    s0_req = 1'b1; s0_vpn2 = 19'h00400; s0_odd_page = 1'b0;
    tick();
    s1_req = 1'b0; s0_req = 1'b0;
    total++; if (s1_found !== 1'b1 || s1_index !== 4'd3 || s1_pfn !== 20'h54321)
      $display("FAIL s1_odd got %b/%h/%h exp 1/3/54321", s1_found, s1_index, s1_pfn); else passed++;
    total++; if ({s1_c, s1_d, s1_v} !== 5'b000_0_1)
      $display("FAIL s1_odd_cdv got %b exp 00001", {s1_c, s1_d, s1_v}); else passed++;
    total++; if (s0_found !== 1'b1 || s0_pfn !== 20'h12345 || {s0_c, s0_d, s0_v} !== 5'b011_1_1)
      $display("FAIL s0_even got %b/%h/%b exp 1/12345/01111", s0_found, s0_pfn, {s0_c, s0_d, s0_v}); else passed++;
    tick();
    total++; if (s1_found !== 1'b1 || s1_pfn !== 20'h54321)
      $display("FAIL s1_hold got %b/%h exp 1/54321", s1_found, s1_pfn); else passed++;
  endtask

  task automatic test_asid_global();
    cp0_entryhi = hi(19'h00000, 8'h11);
    s1_req = 1'b1; s1_vpn2 = 19'h00400; s1_odd_page = 1'b1;
    tick();
    s1_req = 1'b0;
    total++; if ({s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v} !== 30'd0)
      $display("FAIL asid_miss got %b/%h/%h exp 0/0/0", s1_found, s1_index, s1_pfn); else passed++;
    write_entry(4'd3, hi(19'h00400, 8'hA5), lo(20'h12345, 3'd3, 1'b1, 1'b1, 1'b1),
                lo(20'h54321, 3'd0, 1'b0, 1'b1, 1'b1));
    cp0_entryhi = hi(19'h00000, 8'h11);
    s1_req = 1'b1;
    tick();
    s1_req = 1'b0;
    total++; if (s1_found !== 1'b1 || s1_index !== 4'd3 || s1_pfn !== 20'h54321)
      $display("FAIL global_hit got %b/%h/%h exp 1/3/54321", s1_found, s1_index, s1_pfn); else passed++;
  endtask

  task automatic test_same_cycle();
    cp0_index = 32'd7; cp0_entryhi = hi(19'h01234, 8'h22);
    cp0_entrylo0 = lo(20'hABCDE, 3'd2, 1'b0, 1'b1, 1'b0);
    cp0_entrylo1 = lo(20'h0000F, 3'd1, 1'b1, 1'b0, 1'b0);
    tlbwi = 1'b1;
    s0_req = 1'b1; s0_vpn2 = 19'h01234; s0_odd_page = 1'b0;
    tick();
    tlbwi = 1'b0;
    total++; if (s0_found !== 1'b0 || s0_pfn !== 20'd0)
      $display("FAIL wr_same_cycle got %b/%h exp 0/0", s0_found, s0_pfn); else passed++;
    tick();
    s0_req = 1'b0;
    total++; if (s0_found !== 1'b1 || s0_index !== 4'd7 || s0_pfn !== 20'hABCDE || s0_c !== 3'd2)
      $display("FAIL wr_next_cycle got %b/%h/%h/%h exp 1/7/abcde/2", s0_found, s0_index, s0_pfn, s0_c); else passed++;
  endtask

  task automatic test_probe();
    write_entry(4'd9, hi(19'h0ABCD, 8'h33), lo(20'h00009, 3'd0, 1'b0, 1'b1, 1'b0), 32'd0);
    write_entry(4'd5, hi(19'h0ABCD, 8'h33), lo(20'h00005, 3'd0, 1'b0, 1'b1, 1'b0), 32'd0);
    cp0_entryhi = hi(19'h0ABCD, 8'h33);
    tlbp = 1'b1;
    s1_req = 1'b1; s1_vpn2 = 19'h0ABCD; s1_odd_page = 1'b0;
    tick();
    tlbp = 1'b0; s1_req = 1'b0;
    total++; if (is_TLBP !== 1'b1 || index_write_p !== 1'b0 || index_write_index !== 4'd5)
      $display("FAIL probe_hit got %b/%b/%h exp 1/0/5", is_TLBP, index_write_p, index_write_index); else passed++;
    total++; if (s1_index !== 4'd5 || s1_pfn !== 20'h00005)
      $display("FAIL lookup_lowest got %h/%h exp 5/00005", s1_index, s1_pfn); else passed++;
    tick();
    total++; if (is_TLBP !== 1'b0 || index_write_index !== 4'd5)
      $display("FAIL probe_pulse got %b/%h exp 0/5", is_TLBP, index_write_index); else passed++;
    cp0_entryhi = hi(19'h7FFFF, 8'h33);
    tlbp = 1'b1;
    tick();
    tlbp = 1'b0;
    total++; if (is_TLBP !== 1'b1 || index_write_p !== 1'b1 || index_write_index !== 4'd0)
      $display("FAIL probe_miss got %b/%b/%h exp 1/1/0", is_TLBP, index_write_p, index_write_index); else passed++;
  endtask

  task automatic test_tlbr();
    cp0_index = 32'd3;
    tlbr = 1'b1;
    tick();
    tlbr = 1'b0;
    exp_rd = {19'h00400, 8'hA5, 1'b1, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h54321, 3'd0, 1'b0, 1'b1};
    total++; if (is_TLBR !== 1'b1 || TLB_rdata !== exp_rd)
      $display("FAIL tlbr got %b/%h exp 1/%h", is_TLBR, TLB_rdata, exp_rd); else passed++;
    tick();
    total++; if (is_TLBR !== 1'b0 || TLB_rdata !== exp_rd)
      $display("FAIL tlbr_hold got %b/%h exp 0/%h", is_TLBR, TLB_rdata, exp_rd); else passed++;
  endtask

  task automatic test_priority();
    cp0_index = 32'd12; cp0_entryhi = hi(19'h05555, 8'h44);
    cp0_entrylo0 = 32'd0; cp0_entrylo1 = 32'd0;
    tlbwi = 1'b1; tlbp = 1'b1;
    tick();
    tlbwi = 1'b0;
    total++; if (is_TLBP !== 1'b0 || is_TLBR !== 1'b0)
      $display("FAIL prio_wi_p got %b/%b exp 0/0", is_TLBP, is_TLBR); else passed++;
    tlbr = 1'b1;
    tick();
    tlbp = 1'b0; tlbr = 1'b0;
    total++; if (is_TLBP !== 1'b1 || is_TLBR !== 1'b0 || index_write_index !== 4'd12 || index_write_p !== 1'b0)
      $display("FAIL prio_p_r got %b/%b/%h/%b exp 1/0/c/0", is_TLBP, is_TLBR, index_write_index, index_write_p); else passed++;
  endtask

  task automatic test_reset_mid();
    cp0_index = 32'd3;
    tlbr = 1'b1; reset = 1'b1;
    tick();
    tlbr = 1'b0; reset = 1'b0;
    total++; if (is_TLBR !== 1'b0 || TLB_rdata !== 78'd0 || index_write_index !== 4'd0)
      $display("FAIL rst_mid got %b/%h/%h exp 0/0/0", is_TLBR, TLB_rdata, index_write_index); else passed++;
    cp0_entryhi = hi(19'h00000, 8'hA5);
    s1_req = 1'b1; s1_vpn2 = 19'h00400; s1_odd_page = 1'b1;
    tick();
    s1_req = 1'b0;
    total++; if (s1_found !== 1'b0 || s1_pfn !== 20'd0)
      $display("FAIL rst_cleared got %b/%h exp 0/0", s1_found, s1_pfn); else passed++;
  endtask

  initial begin
    reset = 1'b1;
    s0_req = 1'b0; s0_vpn2 = '0; s0_odd_page = 1'b0;
    s1_req = 1'b0; s1_vpn2 = '0; s1_odd_page = 1'b0;
    cp0_index = '0; cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0;
    tlbwi = 1'b0; tlbr = 1'b0; tlbp = 1'b0;
    test_reset();
    test_write_lookup();
    test_asid_global();
    test_same_cycle();
    test_probe();
    test_tlbr();
    test_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
